// File: rtl/cp0_exc_ctrl.sv
// CP0 exception/ERET sequencer: picks the highest-priority cause at MEM/WB, owns Status.EXL,
// pulses the EPC/Cause/BadVAddr commit, then flushes the pipe and redirects fetch.
module cp0_exc_ctrl #(
   parameter logic [31:0] EXC_VECTOR   = 32'hBFC0_0380,
   parameter int          FLUSH_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_valid,
   input  logic [31:0] mem_PC,
   input  logic        mem_BD,
   input  logic [6:0]  mem_exc,
   input  logic [31:0] mem_badvaddr,
   input  logic        mem_eret,
   input  logic        int_pending,
   input  logic [31:0] cp0_EPC_data,
   output logic        exception,
   output logic        EXL,
   output logic        BD,
   output logic [31:0] exc_PC,
   output logic [4:0]  exc_code,
   output logic        badvaddr_we,
   output logic [31:0] badvaddr,
   output logic        flush,
   output logic        redirect_valid,
   output logic [31:0] redirect_PC
);

   typedef enum logic [1:0] {RUN, FLUSH, REDIR} state_t;

   localparam logic [2:0] LP_CNT_INIT = 3'(FLUSH_CYCLES);

   state_t      r_state;
   logic [2:0]  r_cnt;
   logic        r_exception, r_exl, r_bd, r_bwe, r_flush, r_rv;
   logic [31:0] r_exc_pc, r_badvaddr, r_redir_pc;
   logic [4:0]  r_code;

   logic        w_int, w_has_exc, w_accept, w_bwe;
   logic [4:0]  w_code;
   logic [31:0] w_bva;

   // Interrupts are only taken outside exception level.
   assign w_int     = int_pending && !r_exl;
   assign w_has_exc = w_int || (|mem_exc);
   assign w_accept  = (r_state == RUN) && mem_valid && (w_has_exc || mem_eret);

   always_comb begin
      w_code = 5'h00;
      w_bwe  = 1'b0;
      w_bva  = mem_badvaddr;
      if (w_int) begin
         w_code = 5'h00;
      end else if (mem_exc[0]) begin
         w_code = 5'h04;
         w_bwe  = 1'b1;
         w_bva  = mem_PC;
      end else if (mem_exc[1]) begin
         w_code = 5'h0A;
      end else if (mem_exc[2]) begin
         w_code = 5'h0C;
      end else if (mem_exc[3]) begin
         w_code = 5'h08;
      end else if (mem_exc[4]) begin
         w_code = 5'h09;
      end else if (mem_exc[5]) begin
         w_code = 5'h04;
         w_bwe  = 1'b1;
      end else if (mem_exc[6]) begin
         w_code = 5'h05;
         w_bwe  = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= RUN;
         r_cnt       <= 3'd0;
         r_exception <= 1'b0;
         r_exl       <= 1'b0;
         r_bd        <= 1'b0;
         r_exc_pc    <= 32'h0;
         r_code      <= 5'h00;
         r_bwe       <= 1'b0;
         r_badvaddr  <= 32'h0;
         r_flush     <= 1'b0;
         r_rv        <= 1'b0;
         r_redir_pc  <= 32'h0;
      end else begin
         r_exception <= 1'b0;
         r_bwe       <= 1'b0;
         r_rv        <= 1'b0;
         case (r_state)
            RUN: begin
               if (w_accept) begin
                  r_state <= FLUSH;
                  r_cnt   <= LP_CNT_INIT;
                  r_flush <= 1'b1;
                  if (w_has_exc) begin
                     r_exception <= 1'b1;
                     r_exl       <= 1'b1;
                     r_bd        <= mem_BD;
                     r_exc_pc    <= mem_PC;
                     r_code      <= w_code;
                     r_bwe       <= w_bwe;
                     if (w_bwe)
                        r_badvaddr <= w_bva;
                     r_redir_pc  <= EXC_VECTOR;
                  end else begin
                     r_exl      <= 1'b0;
                     r_redir_pc <= cp0_EPC_data;
                  end
               end
            end
            FLUSH: begin
               r_cnt <= r_cnt - 3'd1;
               if (r_cnt == 3'd1) begin
                  r_state <= REDIR;
                  r_flush <= 1'b0;
                  r_rv    <= 1'b1;
               end
            end
            REDIR:   r_state <= RUN;
            default: r_state <= RUN;
         endcase
      end
   end

   assign exception      = r_exception;
   assign EXL            = r_exl;
   assign BD             = r_bd;
   assign exc_PC         = r_exc_pc;
   assign exc_code       = r_code;
   assign badvaddr_we    = r_bwe;
   assign badvaddr       = r_badvaddr;
   assign flush          = r_flush;
   assign redirect_valid = r_rv;
   assign redirect_PC    = r_redir_pc;

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Self-checking bench for cp0_exc_ctrl: cycle-arithmetic reference model, directed
// scenarios with literal expectations, then randomized traffic.
module tb_cp0_exc_ctrl;

   localparam logic [31:0] VEC = 32'hBFC0_0380;
   localparam int          FC  = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_valid, mem_BD, mem_eret, int_pending;
   logic [31:0] mem_PC, mem_badvaddr, cp0_EPC_data;
   logic [6:0]  mem_exc;
   logic        exception, EXL, BD, badvaddr_we, flush, redirect_valid;
   logic [31:0] exc_PC, badvaddr, redirect_PC;
   logic [4:0]  exc_code;

   cp0_exc_ctrl #(.EXC_VECTOR(VEC), .FLUSH_CYCLES(FC)) dut (
      .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_PC(mem_PC), .mem_BD(mem_BD),
      .mem_exc(mem_exc), .mem_badvaddr(mem_badvaddr), .mem_eret(mem_eret),
      .int_pending(int_pending), .cp0_EPC_data(cp0_EPC_data), .exception(exception),
      .EXL(EXL), .BD(BD), .exc_PC(exc_PC), .exc_code(exc_code), .badvaddr_we(badvaddr_we),
      .badvaddr(badvaddr), .flush(flush), .redirect_valid(redirect_valid),
      .redirect_PC(redirect_PC)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // Reference model: expected outputs of the current cycle plus accept bookkeeping.
   int          tcur = 0;
   int          acc_t = -100;
   int          free_at = 0;
   logic        in_rst;
   logic        e_exc, e_exl, e_bd, e_bwe, e_flush, e_rv;
   logic [31:0] e_pc, e_bva, e_rpc;
   logic [4:0]  e_code;
   logic [4:0]  codes [7] = '{5'h04, 5'h0A, 5'h0C, 5'h08, 5'h09, 5'h04, 5'h05};

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s @cycle %0d: got %h, expected %h", nm, tcur, act, exp);
      end
   endtask

   task automatic model_reset();
      in_rst = 1'b1;
      e_exc = 0; e_exl = 0; e_bd = 0; e_bwe = 0; e_flush = 0; e_rv = 0;
      e_pc = 0; e_bva = 0; e_rpc = 0; e_code = 0;
      acc_t = -100; free_at = 0;
   endtask

   // Predict the outputs for the cycle after the next rising edge from the current inputs.
   task automatic model_next();
      int  c;
      logic take_int;
      int  win;
      c = tcur + 1;
      if (rst) begin
         model_reset();
         tcur = c;
         return;
      end
      in_rst = 1'b0;
      e_exc = 0;
      e_bwe = 0;
      if (tcur >= free_at && mem_valid) begin
         take_int = int_pending && !e_exl;
         if (take_int || mem_exc != 0) begin
            win = -1;
            for (int i = 6; i >= 0; i--) if (mem_exc[i]) win = i;
            e_exc  = 1;
            e_exl  = 1;
            e_pc   = mem_PC;
            e_bd   = mem_BD;
            e_code = take_int ? 5'h00 : codes[win];
            if (!take_int && (win == 0 || win == 5 || win == 6)) begin
               e_bwe = 1;
               e_bva = (win == 0) ? mem_PC : mem_badvaddr;
            end
            e_rpc = VEC;
            acc_t = tcur; free_at = tcur + FC + 2;
         end else if (mem_eret) begin
            e_exl = 0;
            e_rpc = cp0_EPC_data;
            acc_t = tcur; free_at = tcur + FC + 2;
         end
      end
      e_flush = (c > acc_t) && (c <= acc_t + FC);
      e_rv    = (c == acc_t + FC + 1);
      tcur = c;
   endtask

   task automatic compare_all();
      chk("exception", 32'(exception), 32'(e_exc));
      chk("EXL", 32'(EXL), 32'(e_exl));
      chk("flush", 32'(flush), 32'(e_flush));
      chk("redirect_valid", 32'(redirect_valid), 32'(e_rv));
      chk("redirect_PC", redirect_PC, e_rpc);
      chk("badvaddr_we", 32'(badvaddr_we), 32'(e_bwe));
      if (e_exc || in_rst) begin
         chk("exc_PC", exc_PC, e_pc);
         chk("BD", 32'(BD), 32'(e_bd));
         chk("exc_code", 32'(exc_code), 32'(e_code));
      end
      if (e_bwe || in_rst) chk("badvaddr", badvaddr, e_bva);
   endtask

   task automatic step();
      model_next();
      @(posedge clk);
      @(negedge clk);
      compare_all();
   endtask

   task automatic clear_in();
      mem_valid = 0; mem_BD = 0; mem_exc = 0; mem_eret = 0; int_pending = 0;
      mem_PC = 0; mem_badvaddr = 0; cp0_EPC_data = 0;
   endtask

   task automatic idle(input int n);
      clear_in();
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic present(input logic [6:0] exc, input logic intr, input logic eret,
                          input logic bd, input logic [31:0] pc, input logic [31:0] bva,
                          input logic [31:0] epc);
      mem_valid = 1; mem_exc = exc; int_pending = intr; mem_eret = eret; mem_BD = bd;
      mem_PC = pc; mem_badvaddr = bva; cp0_EPC_data = epc;
      step();
      clear_in();
   endtask

   initial begin
      clear_in();
      rst = 1;
      model_reset();
      idle(3);
      chk("reset_EXL", 32'(EXL), 32'h0);
      chk("reset_redirect_PC", redirect_PC, 32'h0);
      @(negedge clk);
      rst = 0;
      idle(2);

      // Ov only
      present(7'b000_0100, 0, 0, 0, 32'h8000_1000, 32'h0, 32'h0);
      chk("ov_exception", 32'(exception), 32'h1);
      chk("ov_code", 32'(exc_code), 32'h0C);
      chk("ov_pc", exc_PC, 32'h8000_1000);
      chk("ov_EXL", 32'(EXL), 32'h1);
      chk("ov_flush1", 32'(flush), 32'h1);
      step();
      chk("ov_flush2", 32'(flush), 32'h1);
      step();
      chk("ov_flush_off", 32'(flush), 32'h0);
      chk("ov_redirect_valid", 32'(redirect_valid), 32'h1);
      chk("ov_redirect_PC", redirect_PC, 32'hBFC0_0380);
      idle(FC + 2);

      // ERET with EXL=1
      present(7'b0, 0, 1, 0, 32'h8000_0040, 32'h0, 32'h8000_3000);
      chk("eret_no_exc", 32'(exception), 32'h0);
      chk("eret_EXL", 32'(EXL), 32'h0);
      step(); step();
      chk("eret_redirect_valid", 32'(redirect_valid), 32'h1);
      chk("eret_redirect_PC", redirect_PC, 32'h8000_3000);
      idle(FC + 2);

      // Interrupt beats Syscall while EXL=0, then Syscall wins with EXL=1
      present(7'b000_1000, 1, 0, 1, 32'h8000_2004, 32'h0, 32'h0);
      chk("int_code", 32'(exc_code), 32'h00);
      chk("int_BD", 32'(BD), 32'h1);
      idle(FC + 2);
      present(7'b000_1000, 1, 0, 1, 32'h8000_2004, 32'h0, 32'h0);
      chk("int_masked_code", 32'(exc_code), 32'h08);
      idle(FC + 2);

      // AdEL fetch + AdES, then AdES alone
      present(7'b100_0001, 0, 0, 0, 32'h8000_0ABC, 32'h1234_5678, 32'h0);
      chk("adel_code", 32'(exc_code), 32'h04);
      chk("adel_badvaddr", badvaddr, 32'h8000_0ABC);
      chk("adel_we", 32'(badvaddr_we), 32'h1);
      idle(FC + 2);
      present(7'b100_0000, 0, 0, 0, 32'h8000_0100, 32'h0000_0003, 32'h0);
      chk("ades_code", 32'(exc_code), 32'h05);
      chk("ades_badvaddr", badvaddr, 32'h0000_0003);
      idle(FC + 2);

      // ERET with RI: RI wins, EXL stays 1
      present(7'b000_0010, 0, 1, 0, 32'h8000_0200, 32'h0, 32'h8000_3000);
      chk("eret_ri_exception", 32'(exception), 32'h1);
      chk("eret_ri_code", 32'(exc_code), 32'h0A);
      chk("eret_ri_EXL", 32'(EXL), 32'h1);
      idle(FC + 2);

      // Back-to-back: RI held from T+1 is accepted only at T+4
      present(7'b000_0100, 0, 0, 0, 32'h8000_0300, 32'h0, 32'h0);
      mem_valid = 1; mem_exc = 7'b000_0010; mem_PC = 32'h8000_0304;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("b2b_held_off", 32'(exception), 32'h0);
      end
      step();
      chk("b2b_accept", 32'(exception), 32'h1);
      chk("b2b_code", 32'(exc_code), 32'h0A);
      idle(FC + 2);

      // Reset mid-FLUSH aborts the sequence
      present(7'b001_0000, 0, 0, 0, 32'h8000_0400, 32'h0, 32'h0);
      step();
      rst = 1;
      #1;
      chk("rst_flush", 32'(flush), 32'h0);
      chk("rst_EXL", 32'(EXL), 32'h0);
      model_reset();
      step();
      @(negedge clk);
      rst = 0;
      for (int i = 0; i < FC + 2; i++) begin
         step();
         chk("rst_no_redirect", 32'(redirect_valid), 32'h0);
      end

      // Randomized traffic
      for (int n = 0; n < 600; n++) begin
         mem_valid    = ($urandom_range(0, 3) != 0);
         mem_exc      = ($urandom_range(0, 2) == 0) ? 7'($urandom) : 7'h0;
         int_pending  = ($urandom_range(0, 5) == 0);
         mem_eret     = ($urandom_range(0, 3) == 0);
         mem_BD       = 1'($urandom);
         mem_PC       = $urandom & 32'hFFFF_FFFC;
         mem_badvaddr = $urandom;
         cp0_EPC_data = $urandom;
         step();
      end
      idle(FC + 2);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
